l1_wb_arbiter: RTL and testbench

//  Shares one Wishbone memory port between the L1 icache (M0, read-only refill) and L1 dcache
//  (M1, refill/writeback). Grants one master at a time with round-robin fairness and holds the

---
 rtl/l1_bus_pkg.sv | 7 +
 rtl/rr_arb2.sv | 10 +
 rtl/l1_wb_arbiter.sv | 81 ++++++++
 tb/tb_l1_wb_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1_bus_pkg.sv
// l1_bus_pkg: shared arbiter state encoding, master ids and Wishbone burst-length width
package l1_bus_pkg;
  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} arb_state_e;
  localparam logic MID_ICACHE = 1'b0;
  localparam logic MID_DCACHE = 1'b1;
  localparam int WB_BL_W = 10;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; on a tie the master not served last wins
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_pick
);
  assign o_valid = |i_req;
  assign o_pick = &i_req ? ~i_last : i_req[1];
endmodule

// File: rtl/l1_wb_arbiter.sv
// l1_wb_arbiter: shares one Wishbone port between icache (M0) and dcache (M1), holding grant per line
module l1_wb_arbiter import l1_bus_pkg::*; #(
  parameter int ADDR_LEN = 32,
  parameter int WB_DATA_LEN = 32,
  parameter int BEATS_PER_LINE = 2,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   m0_cyc_i,
  input  logic [ADDR_LEN-1:0]    m0_adr_i,
  input  logic [WB_BL_W-1:0]     m0_bl_i,
  output logic                   m0_ack_o,
  output logic [WB_DATA_LEN-1:0] m0_dat_o,
  input  logic                   m1_cyc_i,
  input  logic                   m1_we_i,
  input  logic [ADDR_LEN-1:0]    m1_adr_i,
  input  logic [WB_BL_W-1:0]     m1_bl_i,
  input  logic [WB_DATA_LEN-1:0] m1_dat_i,
  output logic                   m1_ack_o,
  output logic [WB_DATA_LEN-1:0] m1_dat_o,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [ADDR_LEN-1:0]    wb_adr_o,
  output logic [WB_BL_W-1:0]     wb_bl_o,
  output logic                   wb_bry_o,
  output logic [WB_DATA_LEN-1:0] wb_dat_o,
  input  logic                   wb_ack_i,
  input  logic [WB_DATA_LEN-1:0] wb_dat_i,
  output logic [1:0]             grant_o
);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  arb_state_e r_state;
  logic r_last;
  logic [3:0] r_beat_cnt;
  logic [IW-1:0] r_idle_cnt;
  logic w_own0, w_own1, w_cyc, w_valid, w_pick, w_done, w_tmo;
  rr_arb2 u_rr (
    .i_req  ({m1_cyc_i, m0_cyc_i}),
    .i_last (r_last),
    .o_valid(w_valid),
    .o_pick (w_pick)
  );
  assign w_own0 = r_state == OWN_M0;
  assign w_own1 = r_state == OWN_M1;
  assign w_cyc = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
  assign w_done = wb_ack_i && r_beat_cnt == 4'(BEATS_PER_LINE - 1);
  assign w_tmo = !w_cyc && r_idle_cnt == IW'(IDLE_TIMEOUT - 1);
  assign grant_o = {w_own1, w_own0};
  assign wb_cyc_o = w_cyc;
  assign wb_stb_o = w_cyc;
  assign wb_bry_o = w_cyc;
  assign wb_we_o = w_own1 & m1_we_i;
  assign wb_adr_o = w_own0 ? m0_adr_i : w_own1 ? m1_adr_i : '0;
  assign wb_bl_o = w_own0 ? m0_bl_i : w_own1 ? m1_bl_i : '0;
  assign wb_dat_o = w_own1 ? m1_dat_i : '0;
  assign m0_ack_o = wb_ack_i & w_own0;
  assign m1_ack_o = wb_ack_i & w_own1;
  assign m0_dat_o = w_own0 ? wb_dat_i : '0;
  assign m1_dat_o = w_own1 ? wb_dat_i : '0;
  // grant from IDLE, count beats and quiet cycles, release on line end or owner timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_valid) r_state <= (w_pick == MID_DCACHE) ? OWN_M1 : OWN_M0;
    end else if (w_done || w_tmo) begin
      r_state <= IDLE;
      r_last <= w_own1;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_beat_cnt <= r_beat_cnt + 4'(wb_ack_i);
      r_idle_cnt <= w_cyc ? '0 : r_idle_cnt + IW'(1);
    end
  end
endmodule

// File: tb/tb_l1_wb_arbiter.sv
// tb_l1_wb_arbiter: directed scenarios plus random traffic checked every cycle against a line-level owner model
module tb_l1_wb_arbiter;
  localparam int BEATS = 2;
  localparam int TMO = 8;
  logic clk = 0, rstn = 0;
  logic m0_cyc_i = 0, m1_cyc_i = 0, m1_we_i = 0, wb_ack_i = 0;
  logic [31:0] m0_adr_i = 0, m1_adr_i = 0, m1_dat_i = 0, wb_dat_i = 0;
  logic [9:0] m0_bl_i = 0, m1_bl_i = 0;
  logic m0_ack_o, m1_ack_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_bry_o;
  logic [31:0] m0_dat_o, m1_dat_o, wb_adr_o, wb_dat_o;
  logic [9:0] wb_bl_o;
  logic [1:0] grant_o;
  int checks = 0, fails = 0;
  int m_owner, m_last, m_beats, m_quiet;
  int n_owner, n_last, n_beats, n_quiet;

  l1_wb_arbiter #(.ADDR_LEN(32), .WB_DATA_LEN(32), .BEATS_PER_LINE(BEATS), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .m0_cyc_i(m0_cyc_i), .m0_adr_i(m0_adr_i), .m0_bl_i(m0_bl_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_bl_i(m1_bl_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_bl_o(wb_bl_o),
    .wb_bry_o(wb_bry_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask

  // owner model: -1 means nobody owns the bus; a line ends after BEATS acks or TMO quiet cycles
  always_comb begin
    n_owner = m_owner;
    n_last = m_last;
    n_beats = m_beats;
    n_quiet = m_quiet;
    if (m_owner < 0) begin
      if (m0_cyc_i && m1_cyc_i) n_owner = 1 - m_last;
      else if (m0_cyc_i) n_owner = 0;
      else if (m1_cyc_i) n_owner = 1;
    end else begin
      n_beats = m_beats + (wb_ack_i ? 1 : 0);
      n_quiet = ((m_owner == 0) ? m0_cyc_i : m1_cyc_i) ? 0 : m_quiet + 1;
      if (n_beats == BEATS || n_quiet == TMO) begin
        n_last = m_owner;
        n_owner = -1;
        n_beats = 0;
        n_quiet = 0;
      end
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_owner <= -1;
      m_last <= 1;
      m_beats <= 0;
      m_quiet <= 0;
    end else begin
      m_owner <= n_owner;
      m_last <= n_last;
      m_beats <= n_beats;
      m_quiet <= n_quiet;
    end
  end

  always @(negedge clk) begin
    logic o0, o1, ec;
    o0 = m_owner == 0;
    o1 = m_owner == 1;
    ec = (o0 && m0_cyc_i) || (o1 && m1_cyc_i);
    chk("cyc", wb_cyc_o, ec);
    chk("stb", wb_stb_o, ec);
    chk("bry", wb_bry_o, ec);
    chk("we", wb_we_o, o1 && m1_we_i);
    chk("adr", wb_adr_o, o0 ? m0_adr_i : o1 ? m1_adr_i : 32'h0);
    chk("bl", wb_bl_o, o0 ? m0_bl_i : o1 ? m1_bl_i : 10'h0);
    chk("wdat", wb_dat_o, o1 ? m1_dat_i : 32'h0);
    chk("m0_ack", m0_ack_o, wb_ack_i && o0);
    chk("m1_ack", m1_ack_o, wb_ack_i && o1);
    chk("m0_dat", m0_dat_o, o0 ? wb_dat_i : 32'h0);
    chk("m1_dat", m1_dat_o, o1 ? wb_dat_i : 32'h0);
    chk("grant", grant_o, {o1, o0});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 0;
    {m0_cyc_i, m1_cyc_i, m1_we_i, wb_ack_i} = '0;
    repeat (2) tick();
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_grant", grant_o, 0);
    rstn = 1;
  endtask

  task automatic finish_line(int m);
    wb_ack_i = 1;
    repeat (BEATS) tick();
    wb_ack_i = 0;
    if (m == 0) m0_cyc_i = 0; else m1_cyc_i = 0;
  endtask

  initial begin
    do_reset();
    m0_cyc_i = 1;
    m0_adr_i = 32'h100;
    #1 chk("lat_cyc", wb_cyc_o, 0);
    tick();
    chk("t1_cyc", wb_cyc_o, 1);
    chk("t1_adr", wb_adr_o, 32'h100);
    chk("t1_grant", grant_o, 2'b01);
    wb_ack_i = 1;
    wb_dat_i = 32'h11;
    #1 chk("t1_ack0", m0_ack_o, 1);
    chk("t1_ack1", m1_ack_o, 0);
    chk("t1_dat", m0_dat_o, 32'h11);
    tick();
    chk("t1_ack0b", m0_ack_o, 1);
    tick();
    wb_ack_i = 0;
    m0_cyc_i = 0;
    chk("t1_idle", grant_o, 2'b00);

    do_reset();
    m0_cyc_i = 1;
    m1_cyc_i = 1;
    m1_we_i = 1;
    tick();
    chk("t2_m0", grant_o, 2'b01);
    wb_ack_i = 1;
    repeat (BEATS) tick();
    wb_ack_i = 0;
    m0_cyc_i = 0;
    chk("t2_idle", grant_o, 2'b00);
    tick();
    chk("t2_m1", grant_o, 2'b10);
    chk("t2_we", wb_we_o, 1);
    finish_line(1);
    tick();

    m0_cyc_i = 1;
    m1_cyc_i = 1;
    tick();
    chk("t3_m0", grant_o, 2'b01);
    wb_ack_i = 1;
    tick();
    wb_ack_i = 0;
    m0_cyc_i = 0;
    #1 chk("t3_drop", wb_cyc_o, 0);
    tick();
    chk("t3_hold", grant_o, 2'b01);
    m0_cyc_i = 1;
    wb_ack_i = 1;
    tick();
    wb_ack_i = 0;
    m0_cyc_i = 0;
    tick();
    chk("t3_m1", grant_o, 2'b10);
    finish_line(1);
    tick();

    m1_cyc_i = 1;
    m1_we_i = 1;
    m1_dat_i = 32'hDEADBEEF;
    tick();
    chk("t4_grant", grant_o, 2'b10);
    chk("t4_wdat", wb_dat_o, 32'hDEADBEEF);
    wb_ack_i = 1;
    tick();
    wb_ack_i = 0;
    m1_cyc_i = 0;
    repeat (TMO - 1) tick();
    chk("t4_pre", grant_o, 2'b10);
    tick();
    chk("t4_tmo", grant_o, 2'b00);
    m0_cyc_i = 1;
    m1_cyc_i = 1;
    tick();
    chk("t4_m0", grant_o, 2'b01);
    finish_line(0);
    tick();
    chk("t4_m1", grant_o, 2'b10);
    finish_line(1);
    tick();

    wb_ack_i = 1;
    #1 chk("t5_ack0", m0_ack_o, 0);
    chk("t5_ack1", m1_ack_o, 0);
    tick();
    chk("t5_idle", grant_o, 2'b00);
    wb_ack_i = 0;

    m0_cyc_i = 1;
    tick();
    wb_ack_i = 1;
    #1 chk("t6_pre", wb_cyc_o, 1);
    rstn = 0;
    #1 chk("t6_rst", wb_cyc_o, 0);
    wb_ack_i = 0;
    m1_cyc_i = 1;
    tick();
    rstn = 1;
    tick();
    chk("t6_m0", grant_o, 2'b01);
    finish_line(0);
    tick();
    finish_line(1);
    tick();

    for (int i = 0; i < 3000; i++) begin
      int p;
      p = (i / 200) % 3;
      m0_cyc_i = $urandom_range(0, 3) < (p == 0 ? 3 : p == 1 ? 1 : 2);
      m1_cyc_i = $urandom_range(0, 3) < (p == 0 ? 3 : p == 1 ? 1 : 2);
      m1_we_i = $urandom_range(0, 1);
      m0_adr_i = $urandom;
      m1_adr_i = $urandom;
      m0_bl_i = 10'($urandom);
      m1_bl_i = 10'($urandom);
      m1_dat_i = $urandom;
      wb_dat_i = $urandom;
      wb_ack_i = $urandom_range(0, 2) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
